// File: rtl/bus_io_port_pkg.sv
// Shared definitions for the bus I/O port: register offsets, STATUS bit
// positions and the STATUS word packer used by the read mux.
package bus_io_port_pkg;

    localparam logic OFF_DATA   = 1'b0;
    localparam logic OFF_STATUS = 1'b1;

    localparam int STAT_RX_NOT_EMPTY = 0;
    localparam int STAT_TX_NOT_FULL  = 1;
    localparam int STAT_TX_OVF       = 2;
    localparam int STAT_RX_OVF       = 3;

    function automatic logic [15:0] status_word(
        input logic [7:0] rx_cnt,
        input logic       rx_not_empty,
        input logic       tx_not_full,
        input logic       tx_ovf,
        input logic       rx_ovf
    );
        logic [15:0] w;
        w                    = 16'h0000;
        w[15:8]              = rx_cnt;
        w[STAT_RX_NOT_EMPTY] = rx_not_empty;
        w[STAT_TX_NOT_FULL]  = tx_not_full;
        w[STAT_TX_OVF]       = tx_ovf;
        w[STAT_RX_OVF]       = rx_ovf;
        return w;
    endfunction

endpackage

// File: rtl/bus_io_port_if.sv
// CPU memory-bus address and strobes; the CPU is the master, the port the slave.
interface bus_io_port_if;
    logic [15:0] aBus;
    logic        memNotRead;
    logic        memNotWrite;

    modport master (output aBus, output memNotRead, output memNotWrite);
    modport slave  (input  aBus, input  memNotRead, input  memNotWrite);
endinterface

// File: rtl/bus_io_port_sync_fifo.sv
// Single-clock FIFO with combinational head output; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_eff;
    logic             push_acc;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign dout     = mem_q[rd_ptr_q];
    assign pop_eff  = pop & ~empty;
    assign push_acc = push & (~full | pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop_eff);
        count_d  = count_q + (AW+1)'(push_acc) - (AW+1)'(pop_eff);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; only the write itself is suppressed in reset.
    always_ff @(posedge clock) begin
        if (push_acc && !reset) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/bus_io_port.sv
// Memory-mapped byte I/O responder: DATA/STATUS registers on the CPU bus,
// TX and RX byte FIFOs, sticky overflow flags and an interrupt line.
module bus_io_port
    import bus_io_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3
) (
    input  logic              clock,
    input  logic              reset,
    bus_io_port_if.slave      bus,
    inout  wire  [15:0]       yBus,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady,
    input  logic [7:0]        rxData,
    input  logic              rxStrobe,
    output logic              irq
);
    logic              sel, off, rd, wr;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_pop, rx_full, rx_empty;
    logic [7:0]        rx_head;
    logic [FIFO_AW:0]  tx_count, rx_count;
    logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_set, rx_ovf_set, tx_ovf_clr, rx_ovf_clr;
    logic [15:0]       rdata;
    logic              unused_bits;

    assign sel = (bus.aBus[15:1] == BASE_ADDR[15:1]);
    assign off = bus.aBus[0];
    assign rd  = sel & ~bus.memNotRead & bus.memNotWrite;
    assign wr  = sel & ~bus.memNotWrite & bus.memNotRead;

    assign tx_push = wr & (off == OFF_DATA);
    assign tx_pop  = txValid & txReady;
    assign rx_pop  = rd & (off == OFF_DATA);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (yBus[7:0]),
        .dout  (txData),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rxStrobe),
        .pop   (rx_pop),
        .din   (rxData),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign txValid = ~tx_empty;

    // A full FIFO only overflows when nothing leaves it in the same cycle.
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovf_set = rxStrobe & rx_full & ~rx_pop;
    assign tx_ovf_clr = wr & (off == OFF_STATUS) & yBus[STAT_TX_OVF];
    assign rx_ovf_clr = wr & (off == OFF_STATUS) & yBus[STAT_RX_OVF];

    always_comb begin
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~tx_ovf_clr);
        rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~rx_ovf_clr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    assign irq = ~rx_empty | tx_ovf_q | rx_ovf_q;

    always_comb begin
        rdata = 16'h0000;
        if (off == OFF_DATA) begin
            rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
        end else begin
            rdata = status_word(8'(rx_count), ~rx_empty, ~tx_full, tx_ovf_q, rx_ovf_q);
        end
    end

    assign yBus = rd ? rdata : 16'hzzzz;

    assign unused_bits = &{1'b0, yBus[15:8], tx_count};
endmodule

// File: tb/tb_bus_io_port.sv
// Directed bench for bus_io_port: CPU accesses through the bus interface,
// TX drain and RX fill, with hand-computed expected values.
module tb_bus_io_port;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxData;
    logic        rxStrobe;
    logic        irq;
    logic        drv_en;
    logic [15:0] drv_val;
    tri1  [15:0] yBus;
    int          n_vec = 0;
    int          n_err = 0;

    bus_io_port_if bus ();

    bus_io_port dut (
        .clock    (clk),
        .reset    (rst),
        .bus      (bus),
        .yBus     (yBus),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady),
        .rxData   (rxData),
        .rxStrobe (rxStrobe),
        .irq      (irq)
    );

    assign yBus = drv_en ? drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        bus.aBus        = addr;
        drv_val         = data;
        drv_en          = 1'b1;
        bus.memNotWrite = 1'b0;
        tick();
        bus.memNotWrite = 1'b1;
        drv_en          = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        bus.aBus       = addr;
        bus.memNotRead = 1'b0;
        @(negedge clk);
        d = yBus;
        tick();
        bus.memNotRead = 1'b1;
        chk(tag, d, exp);
    endtask

    task automatic rx_push(input logic [7:0] v);
        rxData   = v;
        rxStrobe = 1'b1;
        tick();
        rxStrobe = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        rst             = 1'b1;
        txReady         = 1'b0;
        rxData          = 8'h00;
        rxStrobe        = 1'b0;
        drv_en          = 1'b0;
        drv_val         = 16'h0000;
        bus.aBus        = 16'h0000;
        bus.memNotRead  = 1'b1;
        bus.memNotWrite = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and idle bus
        rd_chk("status_after_reset", 16'hFF01, 16'h0002);
        chk("txValid_reset", 16'(txValid), 16'h0000);
        chk("irq_reset", 16'(irq), 16'h0000);
        bus.aBus = 16'hFF00;
        @(negedge clk);
        chk("idle_not_driven", yBus, 16'hFFFF);
        tick();

        // Single TX byte, then drain
        do_write(16'hFF00, 16'hAB41);
        chk("txValid_one", 16'(txValid), 16'h0001);
        chk("txData_one", 16'(txData), 16'h0041);
        txReady = 1'b1;
        tick();
        txReady = 1'b0;
        chk("txValid_drained", 16'(txValid), 16'h0000);

        // TX fill, overflow, clear, push-while-pop at full
        for (int i = 0; i < 8; i++) do_write(16'hFF00, {8'hEE, 8'(8'h10 + i)});
        rd_chk("status_tx_full", 16'hFF01, 16'h0000);
        do_write(16'hFF00, 16'h0099);
        rd_chk("status_tx_ovf", 16'hFF01, 16'h0004);
        chk("irq_tx_ovf", 16'(irq), 16'h0001);
        chk("txData_after_drop", 16'(txData), 16'h0010);
        do_write(16'hFF01, 16'h0004);
        rd_chk("status_tx_ovf_clr", 16'hFF01, 16'h0000);
        chk("irq_tx_clr", 16'(irq), 16'h0000);
        txReady = 1'b1;
        do_write(16'hFF00, 16'h0099);
        txReady = 1'b0;
        rd_chk("status_push_pop_full", 16'hFF01, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_drain_%0d", i), 16'(txData), (i == 7) ? 16'h0099 : 16'(8'h11 + i));
            txReady = 1'b1;
            tick();
            txReady = 1'b0;
        end
        chk("txValid_empty", 16'(txValid), 16'h0000);
        rd_chk("status_tx_empty", 16'hFF01, 16'h0002);

        // RX basic path
        rx_push(8'h5A);
        rx_push(8'h3C);
        rd_chk("status_rx_two", 16'hFF01, 16'h0203);
        chk("irq_rx", 16'(irq), 16'h0001);
        rd_chk("rx_read_5a", 16'hFF00, 16'h005A);
        rd_chk("rx_read_3c", 16'hFF00, 16'h003C);
        rd_chk("rx_read_empty", 16'hFF00, 16'h0000);
        rd_chk("status_rx_empty", 16'hFF01, 16'h0002);
        chk("irq_rx_empty", 16'(irq), 16'h0000);

        // RX full: strobe with pop, overflow, set-beats-clear
        for (int i = 0; i < 8; i++) rx_push(8'(8'h80 + i));
        rd_chk("status_rx_full", 16'hFF01, 16'h0803);
        rxData   = 8'h88;
        rxStrobe = 1'b1;
        rd_chk("rx_read_with_strobe", 16'hFF00, 16'h0080);
        rxStrobe = 1'b0;
        rd_chk("status_rx_still_full", 16'hFF01, 16'h0803);
        rx_push(8'h89);
        rd_chk("status_rx_ovf", 16'hFF01, 16'h080B);
        rxData   = 8'h8A;
        rxStrobe = 1'b1;
        do_write(16'hFF01, 16'h0008);
        rxStrobe = 1'b0;
        rd_chk("status_set_wins", 16'hFF01, 16'h080B);
        do_write(16'hFF01, 16'h0008);
        rd_chk("status_rx_ovf_clr", 16'hFF01, 16'h0803);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rx_drain_%0d", i), 16'hFF00, 16'(8'h81 + i));
        rd_chk("status_rx_drained", 16'hFF01, 16'h0002);

        // Misc bus cases
        rx_push(8'h21);
        rd_chk("read_base_plus2", 16'hFF02, 16'hFFFF);
        do_write(16'hFF02, 16'h0066);
        chk("txValid_base_plus2", 16'(txValid), 16'h0000);
        bus.aBus        = 16'hFF00;
        drv_val         = 16'h0077;
        drv_en          = 1'b1;
        bus.memNotRead  = 1'b0;
        bus.memNotWrite = 1'b0;
        @(negedge clk);
        d = yBus;
        tick();
        bus.memNotRead  = 1'b1;
        bus.memNotWrite = 1'b1;
        drv_en          = 1'b0;
        chk("both_strobes_bus", d, 16'h0077);
        chk("both_strobes_tx", 16'(txValid), 16'h0000);
        rd_chk("both_strobes_rx", 16'hFF01, 16'h0103);
        do_write(16'hFF00, 16'h0033);
        chk("txValid_before_rst", 16'(txValid), 16'h0001);
        rst = 1'b1;
        do_write(16'hFF00, 16'h0055);
        rst = 1'b0;
        chk("txValid_rst_write", 16'(txValid), 16'h0000);
        chk("irq_rst", 16'(irq), 16'h0000);
        rd_chk("status_after_rst", 16'hFF01, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
